// File: rtl/rear_light_pkg.sv
// Shared types and constants for the rear lamp duty sequencer.
package rear_light_pkg;

    localparam int DUTY_W = 10;

    localparam logic [DUTY_W-1:0] DUTY_FULL = 10'd1023;
    localparam logic [DUTY_W-1:0] DUTY_OFF  = 10'd0;

    typedef enum logic [2:0] {
        IDLE,
        BRAKE,
        FLASH_ON,
        FLASH_OFF,
        HAZ_ON,
        HAZ_OFF
    } light_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: one-clock tick every TICK_DIV clocks,
// realigned to zero whenever the sequencer changes state.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic c50M,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick = (presc_q == LAST);

    // Count up, wrapping on the tick; a restart aligns the next phase to zero.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (restart || tick) begin
            presc_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge c50M) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/rear_light_sequencer.sv
// Rear lamp duty sequencer: brake onset flash burst, hazard blink and
// dim tail level, driving the 10-bit PWM generator's duty input.
// Build option: define BRAKE_FLASH_EN to enable the brake onset flash burst;
// without it a brake press goes straight to steady full duty.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | no brake/hazard activity, tail level (dim or off)
// BRAKE     | brake held, steady full duty
// FLASH_ON  | onset burst, lamp full
// FLASH_OFF | onset burst, lamp at tail level
// HAZ_ON    | hazard blink, lamp full
// HAZ_OFF   | hazard blink, lamp at tail level
module rear_light_sequencer
    import rear_light_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int FLASH_MS    = 100,
    parameter int FLASH_COUNT = 3,
    parameter int HAZARD_MS   = 500,
    parameter logic [DUTY_W-1:0] DIM_DUTY = 10'd31
) (
    input  logic              c50M,
    input  logic              reset,
    input  logic              brakeActive,
    input  logic              headLightActive,
    input  logic              hazardActive,
    output logic [DUTY_W-1:0] duty,
    output logic              flashActive
);

    if (FLASH_COUNT < 1 || FLASH_COUNT > 15 || FLASH_MS < 1 || HAZARD_MS < 1 || TICK_DIV < 2)
    begin : g_bad_cfg
        $error("rear_light_sequencer: illegal timing parameters");
    end

`ifdef BRAKE_FLASH_EN
    localparam int PH_MAX = max_int(FLASH_MS, HAZARD_MS);
`else
    localparam int PH_MAX = HAZARD_MS;
`endif
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] HAZ_LEN = PH_W'(HAZARD_MS);
`ifdef BRAKE_FLASH_EN
    localparam logic [PH_W-1:0] FLASH_LEN = PH_W'(FLASH_MS);
`endif

    // Synchronizer bit order: {brk, hl, haz}.
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic       brk_dly_q, brk_dly_d;

    light_state_t      state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
`ifdef BRAKE_FLASH_EN
    logic [3:0]        flash_cnt_q, flash_cnt_d;
    logic              flash_q, flash_d;
`endif

    logic            brk, hl, haz;
    logic            brk_rise;
    logic            tick;
    logic            restart;
    logic            timed;
    logic            expire;
    logic [PH_W-1:0] cur_len;

    assign brk      = sync2_q[2];
    assign hl       = sync2_q[1];
    assign haz      = sync2_q[0];
    assign brk_rise = brk & ~brk_dly_q;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick_gen (
        .c50M    (c50M),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Two-flop synchronizers plus one extra brake stage for edge detection.
    always_comb begin
        sync1_d   = {brakeActive, headLightActive, hazardActive};
        sync2_d   = sync1_q;
        brk_dly_d = brk;
    end

    // Phase length of the current state and its expiry on a tick.
    always_comb begin
        cur_len = '0;
        timed   = 1'b0;
        unique case (state_q)
`ifdef BRAKE_FLASH_EN
            FLASH_ON, FLASH_OFF: begin
                cur_len = FLASH_LEN;
                timed   = 1'b1;
            end
`endif
            HAZ_ON, HAZ_OFF: begin
                cur_len = HAZ_LEN;
                timed   = 1'b1;
            end
            default: begin
                cur_len = '0;
                timed   = 1'b0;
            end
        endcase
        expire = timed && tick && ((phase_q + PH_W'(1)) == cur_len);
    end

    // Next-state, phase/flash counters and registered outputs derived from next state.
    always_comb begin
        state_d = state_q;
`ifdef BRAKE_FLASH_EN
        flash_cnt_d = flash_cnt_q;
`endif
        phase_d = '0;
        if (timed && tick) begin
            phase_d = phase_q + PH_W'(1);
        end else if (timed) begin
            phase_d = phase_q;
        end

        if (brk_rise) begin
`ifdef BRAKE_FLASH_EN
            state_d     = FLASH_ON;
            flash_cnt_d = '0;
`else
            state_d = BRAKE;
`endif
        end else if (!brk && (state_q inside {BRAKE, FLASH_ON, FLASH_OFF})) begin
            state_d = haz ? HAZ_ON : IDLE;
`ifdef BRAKE_FLASH_EN
            flash_cnt_d = '0;
`endif
        end else begin
            unique case (state_q)
`ifdef BRAKE_FLASH_EN
                FLASH_ON: begin
                    if (expire) begin
                        flash_cnt_d = flash_cnt_q + 4'd1;
                        state_d     = (flash_cnt_d == 4'(FLASH_COUNT)) ? BRAKE : FLASH_OFF;
                    end
                end
                FLASH_OFF: begin
                    if (expire) begin
                        state_d = FLASH_ON;
                    end
                end
`endif
                IDLE: begin
                    if (haz && !brk) begin
                        state_d = HAZ_ON;
                    end
                end
                BRAKE: begin
                    state_d = BRAKE;
                end
                HAZ_ON: begin
                    if (!haz) begin
                        state_d = IDLE;
                    end else if (expire) begin
                        state_d = HAZ_OFF;
                    end
                end
                HAZ_OFF: begin
                    if (!haz) begin
                        state_d = IDLE;
                    end else if (expire) begin
                        state_d = HAZ_ON;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Every transition starts a fresh phase so each phase is exactly length x TICK_DIV.
        restart = (state_d != state_q);
        if (restart) begin
            phase_d = '0;
        end

        duty_d = hl ? DIM_DUTY : DUTY_OFF;
        if (state_d inside {BRAKE, FLASH_ON, HAZ_ON}) begin
            duty_d = DUTY_FULL;
        end
`ifdef BRAKE_FLASH_EN
        flash_d = (state_d inside {FLASH_ON, FLASH_OFF});
`endif
    end

    // State, counters, synchronizers and output registers.
    always_ff @(posedge c50M) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            brk_dly_q <= 1'b0;
            state_q   <= IDLE;
            phase_q   <= '0;
            duty_q    <= DUTY_OFF;
`ifdef BRAKE_FLASH_EN
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            brk_dly_q <= brk_dly_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            duty_q    <= duty_d;
`ifdef BRAKE_FLASH_EN
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
`endif
        end
    end

    assign duty = duty_q;
`ifdef BRAKE_FLASH_EN
    assign flashActive = flash_q;
`else
    assign flashActive = 1'b0;
`endif

endmodule

// File: tb/tb_rear_light_sequencer.sv
// Scoreboard bench for rear_light_sequencer: a clock-counting lamp model
// predicts duty/flashActive per edge, a monitor compares on the falling edge.
module tb_rear_light_sequencer;

    localparam int TICK_DIV    = 10;
    localparam int FLASH_MS    = 2;
    localparam int HAZARD_MS   = 5;
    localparam int FLASH_COUNT = 3;
    localparam logic [9:0] DIM = 10'd31;
`ifdef BRAKE_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_BRAKE = 1;
    localparam int M_FLON  = 2;
    localparam int M_FLOFF = 3;
    localparam int M_HZON  = 4;
    localparam int M_HZOFF = 5;

    bit         c50M = 1'b0;
    logic       reset;
    logic       brakeActive, headLightActive, hazardActive;
    logic [9:0] duty;
    logic       flashActive;

    rear_light_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .FLASH_MS    (FLASH_MS),
        .FLASH_COUNT (FLASH_COUNT),
        .HAZARD_MS   (HAZARD_MS),
        .DIM_DUTY    (DIM)
    ) dut (
        .c50M            (c50M),
        .reset           (reset),
        .brakeActive     (brakeActive),
        .headLightActive (headLightActive),
        .hazardActive    (hazardActive),
        .duty            (duty),
        .flashActive     (flashActive)
    );

    always #5 c50M = ~c50M;

    int n_checks = 0;
    int n_fail   = 0;
    int saw_flash = 0;
    bit started = 1'b0;

    logic [10:0] sb[$];

    // Reference model state: mode, clocks spent in current mode, flashes done.
    int m_mode = M_IDLE;
    int m_el   = 0;
    int m_nf   = 0;
    bit sy_brk[2], sy_hl[2], sy_haz[2];
    bit brk_prev;

    function automatic int phase_clocks(input int mode);
        if (mode == M_FLON || mode == M_FLOFF) return FLASH_MS * TICK_DIV;
        if (mode == M_HZON || mode == M_HZOFF) return HAZARD_MS * TICK_DIV;
        return 0;
    endfunction

    always @(posedge c50M) begin : ref_model
        bit brk, hl, haz, rise, last;
        int nxt;
        logic [9:0] e_duty;
        started = 1'b1;
        if (reset) begin
            m_mode = M_IDLE; m_el = 0; m_nf = 0;
            sy_brk = '{0, 0}; sy_hl = '{0, 0}; sy_haz = '{0, 0};
            brk_prev = 1'b0;
            sb.push_back({10'd0, 1'b0});
        end else begin
            brk  = sy_brk[1];
            hl   = sy_hl[1];
            haz  = sy_haz[1];
            rise = brk && !brk_prev;
            last = (phase_clocks(m_mode) > 0) && (m_el + 1 == phase_clocks(m_mode));
            nxt  = m_mode;
            if (rise) begin
                nxt = FLASH_EN ? M_FLON : M_BRAKE;
                m_nf = 0;
            end else if (!brk && (m_mode == M_BRAKE || m_mode == M_FLON || m_mode == M_FLOFF)) begin
                nxt = haz ? M_HZON : M_IDLE;
                m_nf = 0;
            end else if (m_mode == M_FLON && last) begin
                m_nf++;
                nxt = (m_nf == FLASH_COUNT) ? M_BRAKE : M_FLOFF;
            end else if (m_mode == M_FLOFF && last) begin
                nxt = M_FLON;
            end else if (m_mode == M_IDLE && haz && !brk) begin
                nxt = M_HZON;
            end else if ((m_mode == M_HZON || m_mode == M_HZOFF) && !haz) begin
                nxt = M_IDLE;
            end else if (m_mode == M_HZON && last) begin
                nxt = M_HZOFF;
            end else if (m_mode == M_HZOFF && last) begin
                nxt = M_HZON;
            end
            m_el   = (nxt != m_mode) ? 0 : m_el + 1;
            m_mode = nxt;
            brk_prev  = brk;
            sy_brk[1] = sy_brk[0]; sy_brk[0] = brakeActive;
            sy_hl[1]  = sy_hl[0];  sy_hl[0]  = headLightActive;
            sy_haz[1] = sy_haz[0]; sy_haz[0] = hazardActive;
            e_duty = (m_mode == M_BRAKE || m_mode == M_FLON || m_mode == M_HZON) ? 10'd1023
                                                                                  : (hl ? DIM : 10'd0);
            sb.push_back({e_duty, (m_mode == M_FLON || m_mode == M_FLOFF)});
        end
    end

    always @(negedge c50M) begin : monitor
        logic [10:0] exp_v;
        if (started) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: no expected entry for output duty=%0d", $time, duty);
            end else begin
                exp_v = sb.pop_front();
                if (duty !== exp_v[10:1]) begin
                    n_fail++;
                    $display("FAIL duty at %0t: got %0d, expected %0d", $time, duty, exp_v[10:1]);
                end
                n_checks++;
                if (flashActive !== exp_v[0]) begin
                    n_fail++;
                    $display("FAIL flashActive at %0t: got %0b, expected %0b", $time, flashActive, exp_v[0]);
                end
                if (exp_v[0]) saw_flash++;
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge c50M);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1;
        brakeActive = 1'b0; headLightActive = 1'b0; hazardActive = 1'b0;
        hold(3);
        reset = 1'b0;
        hold(5);
        headLightActive = 1'b1;           hold(10);
        brakeActive = 1'b1;               hold(150);
        brakeActive = 1'b0;               hold(20);
        brakeActive = 1'b1;               hold(50);
        brakeActive = 1'b0;
        headLightActive = 1'b0;
        hazardActive = 1'b1;              hold(130);
        brakeActive = 1'b1;               hold(80);
        brakeActive = 1'b0;               hold(60);
        hazardActive = 1'b0;
        headLightActive = 1'b1;           hold(10);
        brakeActive = 1'b1;               hold(28);
        reset = 1'b1;                     hold(1);
        reset = 1'b0;                     hold(100);
        brakeActive = 1'b0;               hold(10);
        for (int i = 0; i < 60; i++) begin
            brakeActive     = 1'($urandom_range(0, 1));
            headLightActive = 1'($urandom_range(0, 1));
            hazardActive    = 1'($urandom_range(0, 1));
            hold($urandom_range(1, 120));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                hold(1);
                reset = 1'b0;
            end
        end
        hold(5);
        @(negedge c50M);
        #1;
`ifdef BRAKE_FLASH_EN
        n_checks++;
        if (saw_flash == 0) begin
            n_fail++;
            $display("FAIL flash_burst_seen: got %0d flash cycles, expected more than 0", saw_flash);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
